mem_port_arbiter: RTL

Shares one single-port 2048x32 SRAM macro between the instruction-fetch port and the data-memory port of the 5-stage pipeline, so a unified memory replaces the separate instruction and data memories. Each cycle it issues at most one SRAM access, returns read data one cycle later on the owning port, and enforces a bounded data-priority policy so fetch is never starved. The fetch port sits between PC/IF_ID and the SRAM; the data port sits between EX_MEM and MEM_WB. A deasserted grant is the stall indication to the hazard logic.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port SRAM between the instruction-fetch port
//            and the data-memory port. Issues at most one access per cycle.
//            Data has priority, but only for a bounded run while fetch waits.
//            Read data returns one cycle later on the port that issued it.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int ADDR_W       = 11,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,

    // instruction-fetch port (read-only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WIDTH-1:0]  if_rdata,

    // data-memory port (read/write)
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [WIDTH-1:0]  dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [WIDTH-1:0]  dm_rdata,

    // single-port SRAM macro
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [WIDTH-1:0]  sram_d,
    input  logic [WIDTH-1:0]  sram_q
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    // Run limit held in the same 4-bit width as the run counter so the
    // saturation compare has matching operands.
    localparam logic [3:0] C_MAX_RUN = 4'(MAX_DATA_RUN);

    // Issue state records what was sent to the SRAM in the previous cycle,
    // which is exactly what decides where this cycle's sram_q belongs.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_DM = 2'd2,
        WR_DM = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [3:0] r_run_cnt;
    logic [3:0] w_run_cnt_nxt;

    logic       w_fetch_forced;
    logic       w_if_gnt;
    logic       w_dm_gnt;

    // ------------------------------------------------------------------------
    // Grant logic
    // ------------------------------------------------------------------------
    // Fetch is forced through only once data has used up its allowed run.
    assign w_fetch_forced = (r_run_cnt == C_MAX_RUN);

    // Combinational arbitration: data first unless fetch has waited too long.
    always_comb begin
        w_dm_gnt = 1'b0;
        w_if_gnt = 1'b0;
        if (dm_req && !(if_req && w_fetch_forced)) begin
            w_dm_gnt = 1'b1;
        end else if (if_req) begin
            w_if_gnt = 1'b1;
        end
    end

    assign if_gnt = w_if_gnt;
    assign dm_gnt = w_dm_gnt;

    // ------------------------------------------------------------------------
    // Data-run counter
    // ------------------------------------------------------------------------
    // Counts data grants taken while fetch is waiting; any fetch grant or a
    // cycle without a fetch request ends the run. Saturates at the limit.
    always_comb begin
        w_run_cnt_nxt = r_run_cnt;
        if (w_if_gnt || !if_req) begin
            w_run_cnt_nxt = 4'd0;
        end else if (w_dm_gnt && (r_run_cnt != C_MAX_RUN)) begin
            w_run_cnt_nxt = r_run_cnt + 4'd1;
        end
    end

    // Run counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_cnt <= 4'd0;
        end else begin
            r_run_cnt <= w_run_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Issue state machine
    // ------------------------------------------------------------------------
    // Next state is simply the kind of access granted this cycle.
    always_comb begin
        w_state_nxt = IDLE;
        if (w_dm_gnt) begin
            w_state_nxt = dm_we ? WR_DM : RD_DM;
        end else if (w_if_gnt) begin
            w_state_nxt = RD_IF;
        end
    end

    // State register; reset drops any read that was in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // SRAM command
    // ------------------------------------------------------------------------
    // Command goes out in the grant cycle; bus is parked at zero when idle.
    always_comb begin
        sram_cen = 1'b1;
        sram_wen = 1'b1;
        sram_a   = '0;
        sram_d   = '0;
        if (w_dm_gnt) begin
            sram_cen = 1'b0;
            sram_a   = dm_addr;
            if (dm_we) begin
                sram_wen = 1'b0;
                sram_d   = dm_wdata;
            end
        end else if (w_if_gnt) begin
            sram_cen = 1'b0;
            sram_a   = if_addr;
        end
    end

    // ------------------------------------------------------------------------
    // Read response steering
    // ------------------------------------------------------------------------
    // Route sram_q to the owning port; non-owning port sees zero so stale
    // macro output never leaks into the pipeline.
    always_comb begin
        if_rvalid = (r_state == RD_IF);
        dm_rvalid = (r_state == RD_DM);
        if_rdata  = if_rvalid ? sram_q : '0;
        dm_rdata  = dm_rvalid ? sram_q : '0;
    end

endmodule
`default_nettype wire
